// File: rtl/avalon_mem_tester.sv
// Avalon-MM memory tester: writes seed+index, reads back, counts mismatches.
// Define MEMTEST_INV_PASS_EN to add a second pass using the inverted pattern.
module avalon_mem_tester #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RDATA,
    FIN
  } state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W:0]   index;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] pattern;
  logic              last;
  logic              accept;
  logic              mismatch;
  logic              err_max;

`ifdef MEMTEST_INV_PASS_EN
  logic              inv;
`endif

  assign cur_addr = base_q + index[ADDR_W-1:0];
  assign sum      = seed_q + DATA_W'(index);
  assign last     = (index == count_q - ONE);
  assign accept   = !avm_waitrequest;
  assign err_max  = &err_count;

`ifdef MEMTEST_INV_PASS_EN
  assign pattern  = inv ? ~sum : sum;
`else
  assign pattern  = sum;
`endif

  // Read latency is one cycle, so RDATA compares the word issued by READ
  assign mismatch = (state == RDATA) && (avm_readdata != pattern);

  always_comb begin
    state_nx       = state;
    busy           = (state != IDLE);
    done           = (state == FIN);
    avm_write      = (state == WRITE);
    avm_read       = (state == READ);
    avm_address    = '0;
    avm_byteenable = '0;
    avm_writedata  = '0;
    if (avm_write || avm_read) begin
      avm_address    = cur_addr;
      avm_byteenable = '1;
    end
    if (avm_write) avm_writedata = pattern;
    unique case (state)
      IDLE:
        if (start) state_nx = (count == '0) ? FIN : WRITE;
      WRITE:
        if (accept && last) state_nx = READ;
      READ:
        if (accept) state_nx = RDATA;
      RDATA:
`ifdef MEMTEST_INV_PASS_EN
        if (last) state_nx = inv ? FIN : WRITE;
        else      state_nx = READ;
`else
        state_nx = last ? FIN : READ;
`endif
      FIN:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      base_q         <= '0;
      count_q        <= '0;
      seed_q         <= '0;
      index          <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
`ifdef MEMTEST_INV_PASS_EN
      inv            <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE:
          if (start) begin
            base_q         <= base;
            count_q        <= count;
            seed_q         <= seed;
            index          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= (count == '0);
`ifdef MEMTEST_INV_PASS_EN
            inv            <= 1'b0;
`endif
          end
        WRITE:
          if (accept) index <= last ? '0 : index + ONE;
        RDATA: begin
          if (mismatch) begin
            if (!err_max) err_count <= err_count + ONE;
            if (err_count == '0) first_err_addr <= cur_addr;
          end
          index <= last ? '0 : index + ONE;
`ifdef MEMTEST_INV_PASS_EN
          if (last) inv <= 1'b1;
`endif
          // pass is ready in the same cycle done is raised
          if (state_nx == FIN) pass <= (err_count == '0) && !mismatch;
        end
        default: ;
      endcase
    end
  end

endmodule
